// File: rtl/seq_pkg.sv
// Shared types and widths for the sequence generator and stream checker.
package seq_pkg;

  localparam int SEQ_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } chk_state_t;

endpackage

// File: rtl/seq_hist_sr.sv
// Three-deep term history; h0 holds the newest accepted term.
module seq_hist_sr
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] h0,
  output logic [DATA_W-1:0] h1,
  output logic [DATA_W-1:0] h2
);

  logic [DATA_W-1:0] h0_q, h0_d;
  logic [DATA_W-1:0] h1_q, h1_d;
  logic [DATA_W-1:0] h2_q, h2_d;

  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    h2_d = h2_q;
    if (clr) begin
      h0_d = '0;
      h1_d = '0;
      h2_d = '0;
    end else if (shift_en) begin
      h2_d = h1_q;
      h1_d = h0_q;
      h0_d = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end

  assign h0 = h0_q;
  assign h1 = h1_q;
  assign h2 = h2_q;

endmodule

// File: rtl/seq_stream_checker.sv
// Checks a(n) = a(n-2) + a(n-3) on a stream after a seed prefix;
// records the first mismatch and raises a sticky done or err.
module seq_stream_checker
  import seq_pkg::*;
#(
  parameter  int DATA_W    = SEQ_DATA_W,
  parameter  int PRIME_LEN = 5,
  parameter  int NUM_TERMS = 15,
  localparam int CNT_W     = $clog2(NUM_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
);

  chk_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  err_idx_q, err_idx_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d;
  logic [DATA_W-1:0] err_got_q, err_got_d;

  logic              accept;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] h0, h1, h2;

  assign accept = in_valid &&
                  (state_q == IDLE || state_q == PRIME ||
                   state_q == CHECK);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign expected = h1 + h2;

  seq_hist_sr #(
    .DATA_W (DATA_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (accept && !clr),
    .din      (in_data),
    .h0       (h0),
    .h1       (h1),
    .h2       (h2)
  );

  // h0 (the newest term) is not part of the recurrence
  logic unused_h0;
  assign unused_h0 = ^h0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_idx_d = err_idx_q;
    err_exp_d = err_exp_q;
    err_got_d = err_got_q;
    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      err_idx_d = '0;
      err_exp_d = '0;
      err_got_d = '0;
    end else if (accept) begin
      cnt_d = cnt_inc;
      unique case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          if (cnt_inc == CNT_W'(PRIME_LEN))
            state_d = CHECK;
        end
        CHECK: begin
          if (in_data != expected) begin
            state_d   = FAIL;
            err_idx_d = cnt_q;
            err_exp_d = expected;
            err_got_d = in_data;
          end else if (cnt_inc == CNT_W'(NUM_TERMS)) begin
            state_d = DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_idx_q <= '0;
      err_exp_q <= '0;
      err_got_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_idx_q <= err_idx_d;
      err_exp_q <= err_exp_d;
      err_got_q <= err_got_d;
    end
  end

  assign term_cnt = cnt_q;
  assign busy     = (state_q == PRIME) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign err      = (state_q == FAIL);
  assign err_idx  = err_idx_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed bench for seq_stream_checker (default and PRIME_LEN=3 builds).
module tb_seq_stream_checker;

  localparam int CW = 4;

  logic clk = 0;
  logic rst = 1;
  logic clr = 0;
  logic in_valid = 0;
  logic [7:0] in_data = 0;
  logic [CW-1:0] term_cnt, err_idx;
  logic busy, done, err;
  logic [7:0] err_exp, err_got;

  logic clr3 = 0;
  logic v3 = 0;
  logic [7:0] d3 = 0;
  logic [CW-1:0] cnt3, idx3;
  logic busy3, done3, err3;
  logic [7:0] exp3, got3;

  int n_run = 0;
  int n_fail = 0;
  logic [7:0] sv [15];

  always #5 clk = ~clk;

  seq_stream_checker dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data),
    .term_cnt(term_cnt), .busy(busy),
    .done(done), .err(err),
    .err_idx(err_idx), .err_exp(err_exp),
    .err_got(err_got)
  );

  seq_stream_checker #(.PRIME_LEN(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr3),
    .in_valid(v3), .in_data(d3),
    .term_cnt(cnt3), .busy(busy3),
    .done(done3), .err(err3),
    .err_idx(idx3), .err_exp(exp3),
    .err_got(got3)
  );

  task automatic send(input logic v,
                      input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic send3(input logic [7:0] d);
    @(negedge clk);
    v3 = 1;
    d3 = d;
  endtask

  task automatic do_clr();
    @(negedge clk);
    in_valid = 0;
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic chk_pass(input string nm);
    n_run++;
    if (done !== 1 || err !== 0 || busy !== 0 || term_cnt !== 15) begin
      n_fail++;
      $display("FAIL %s: done=%0b err=%0b busy=%0b cnt=%0d want 1 0 0 15",
               nm, done, err, busy, term_cnt);
    end
  endtask

  task automatic full_stream();
    for (int i = 0; i < 15; i++) send(1, sv[i]);
    send(0, 0);
  endtask

  task automatic test_reset();
    n_run++;
    if ({term_cnt, busy, done, err, err_idx, err_exp, err_got} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h want 0",
               {term_cnt, busy, done, err, err_idx, err_exp, err_got});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_pass();
    for (int i = 0; i < 14; i++) send(1, sv[i]);
    send(1, sv[14]);
    @(posedge clk); #1;
    n_run++;
    if (done !== 1 || term_cnt !== 15) begin
      n_fail++;
      $display("FAIL pass_latency: done=%0b cnt=%0d want 1 15",
               done, term_cnt);
    end
    send(0, 0);
    chk_pass("pass");
  endtask

  task automatic test_mismatch();
    do_clr();
    for (int i = 0; i < 15; i++)
      send(1, (i == 8) ? 8'd8 : sv[i]);
    send(0, 0);
    n_run++;
    if (err !== 1 || done !== 0 || busy !== 0 || err_idx !== 8 ||
        err_exp !== 7 || err_got !== 8 || term_cnt !== 9) begin
      n_fail++;
      $display("FAIL mismatch: err=%0b done=%0b busy=%0b idx=%0d exp=%0d got=%0d cnt=%0d want 1 0 0 8 7 8 9",
               err, done, busy, err_idx, err_exp, err_got, term_cnt);
    end
  endtask

  task automatic test_wrap();
    send3(200); send3(100); send3(200); send3(44);
    @(negedge clk);
    v3 = 0;
    n_run++;
    if (err3 !== 0 || busy3 !== 1 || cnt3 !== 4) begin
      n_fail++;
      $display("FAIL wrap_ok: err=%0b busy=%0b cnt=%0d want 0 1 4",
               err3, busy3, cnt3);
    end
    clr3 = 1;
    @(negedge clk);
    clr3 = 0;
    n_run++;
    if (cnt3 !== 0 || busy3 !== 0) begin
      n_fail++;
      $display("FAIL wrap_clr: cnt=%0d busy=%0b want 0 0", cnt3, busy3);
    end
    send3(200); send3(100); send3(200); send3(45);
    @(negedge clk);
    v3 = 0;
    n_run++;
    if (err3 !== 1 || exp3 !== 44 || got3 !== 45 || idx3 !== 3) begin
      n_fail++;
      $display("FAIL wrap_bad: err=%0b exp=%0d got=%0d idx=%0d want 1 44 45 3",
               err3, exp3, got3, idx3);
    end
  endtask

  task automatic test_gaps();
    do_clr();
    for (int i = 0; i < 15; i++) begin
      send(1, sv[i]);
      if (i % 3 == 1) begin
        send(0, 8'hAA);
        send(0, 8'h55);
      end
      if (i == 5) begin
        send(0, 8'hFF);
        n_run++;
        if (term_cnt !== 6 || busy !== 1) begin
          n_fail++;
          $display("FAIL gaps_mid: cnt=%0d busy=%0b want 6 1",
                   term_cnt, busy);
        end
      end
    end
    send(0, 0);
    chk_pass("gaps");
  endtask

  task automatic test_clr_drop();
    do_clr();
    for (int i = 0; i < 7; i++) send(1, sv[i]);
    @(negedge clk);
    clr = 1;
    in_valid = 1;
    in_data = sv[7];
    @(negedge clk);
    clr = 0;
    in_valid = 0;
    n_run++;
    if (term_cnt !== 0 || busy !== 0 || done !== 0 || err !== 0) begin
      n_fail++;
      $display("FAIL clr_drop: cnt=%0d busy=%0b done=%0b err=%0b want 0 0 0 0",
               term_cnt, busy, done, err);
    end
    full_stream();
    chk_pass("clr_restart");
  endtask

  task automatic test_async_rst();
    do_clr();
    for (int i = 0; i < 8; i++) send(1, sv[i]);
    send(0, 0);
    n_run++;
    if (busy !== 1 || term_cnt !== 8) begin
      n_fail++;
      $display("FAIL pre_rst: busy=%0b cnt=%0d want 1 8", busy, term_cnt);
    end
    #2 rst = 1;
    #1;
    n_run++;
    if ({term_cnt, busy, done, err, err_idx, err_exp, err_got} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: outputs=%h want 0",
               {term_cnt, busy, done, err, err_idx, err_exp, err_got});
    end
    @(negedge clk);
    rst = 0;
    full_stream();
    chk_pass("post_rst");
  endtask

  task automatic test_terminal();
    for (int i = 0; i < 4; i++) send(1, 8'd3);
    send(0, 0);
    n_run++;
    if (term_cnt !== 15 || done !== 1) begin
      n_fail++;
      $display("FAIL terminal: cnt=%0d done=%0b want 15 1", term_cnt, done);
    end
  endtask

  initial begin
    sv = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5,
           8'd7, 8'd9, 8'd12, 8'd16, 8'd21, 8'd28, 8'd37};
    #12;
    test_reset();
    test_pass();
    test_terminal();
    test_mismatch();
    test_wrap();
    test_gaps();
    test_clr_drop();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
